// File: rtl/div_arbiter.sv
// Shares one iterative divide core between two requesters with round-robin priority.
// Latency: grant is combinational; response pulse arrives one cycle after the core's ready.
// Backpressure: requests wait (req_ready_o low) while the core is owned; responses are never stalled.
module div_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ-1:0][31:0] req_dividend_i,
  input  logic [NREQ-1:0][31:0] req_divisor_i,
  input  logic [NREQ-1:0][2:0]  req_op_i,
  input  logic [NREQ-1:0][4:0]  req_waddr_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ-1:0]       flush_i,
  output logic [NREQ-1:0]       resp_valid_o,
  output logic [31:0]           resp_result_o,
  output logic [4:0]            resp_waddr_o,
  output logic                  busy_o,
  output logic [31:0]           div_dividend_o,
  output logic [31:0]           div_divisor_o,
  output logic [2:0]            div_op_o,
  output logic [4:0]            div_waddr_o,
  output logic                  div_start_o,
  input  logic [31:0]           div_result_i,
  input  logic                  div_ready_i,
  input  logic                  div_busy_i
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_q, rr_d;
  logic [31:0]     dividend_q, dividend_d;
  logic [31:0]     divisor_q, divisor_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  logic [31:0]     resp_result_q, resp_result_d;
  logic [4:0]      resp_waddr_q, resp_waddr_d;
  logic [NREQ-1:0] eff;
  logic            grant_vld;
  logic            grant_idx;
  logic            unused_div_busy;

  // The core's busy flag carries no information the ready/start handshake lacks.
  assign unused_div_busy = div_busy_i;

  // Choose the winner among unflushed requests; rr_q breaks a tie.
  always_comb begin
    eff       = req_valid_i & ~flush_i;
    grant_vld = |eff;
    grant_idx = (&eff) ? rr_q : eff[1];
  end

  // Next-state, grant, start-line and response logic.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    dividend_d    = dividend_q;
    divisor_d     = divisor_q;
    op_d          = op_q;
    waddr_d       = waddr_q;
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    resp_waddr_d  = resp_waddr_q;
    req_ready_o   = '0;
    div_start_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A grant during reset would be discarded, so do not advertise one.
        if (grant_vld && !rst) begin
          req_ready_o[grant_idx] = 1'b1;
          dividend_d = req_dividend_i[grant_idx];
          divisor_d  = req_divisor_i[grant_idx];
          op_d       = req_op_i[grant_idx];
          waddr_d    = req_waddr_i[grant_idx];
          owner_d    = grant_idx;
          rr_d       = ~grant_idx;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Drop start in the ready cycle so the core does not relaunch.
        div_start_o = ~div_ready_i;
        if (flush_i[owner_q]) begin
          // Flush beats a coincident ready; the IDLE cycle lowers start and aborts the core.
          state_d = ST_IDLE;
        end else if (div_ready_i) begin
          resp_valid_d[owner_q] = 1'b1;
          resp_result_d         = div_result_i;
          resp_waddr_d          = waddr_q;
          state_d               = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched operand registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= 1'b0;
      rr_q          <= 1'b0;
      dividend_q    <= '0;
      divisor_q     <= '0;
      op_q          <= '0;
      waddr_q       <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      resp_waddr_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_q          <= rr_d;
      dividend_q    <= dividend_d;
      divisor_q     <= divisor_d;
      op_q          <= op_d;
      waddr_q       <= waddr_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      resp_waddr_q  <= resp_waddr_d;
    end
  end

  assign busy_o         = (state_q == ST_BUSY);
  assign resp_valid_o   = resp_valid_q;
  assign resp_result_o  = resp_result_q;
  assign resp_waddr_o   = resp_waddr_q;
  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign div_op_o       = op_q;
  assign div_waddr_o    = waddr_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter with a behavioural divide core and a response scoreboard.
// Latency: core takes 35 start cycles (2 for a zero divisor) before raising ready.
// Backpressure: requests are held until req_ready_o; responses are checked as they appear.
module tb_div_arbiter;

  localparam logic [2:0] OP_DIV  = 3'd0;
  localparam logic [2:0] OP_DIVU = 3'd1;
  localparam logic [2:0] OP_REM  = 3'd2;
  localparam logic [2:0] OP_REMU = 3'd3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid_i;
  logic [1:0][31:0] req_dividend_i;
  logic [1:0][31:0] req_divisor_i;
  logic [1:0][2:0]  req_op_i;
  logic [1:0][4:0]  req_waddr_i;
  logic [1:0]       req_ready_o;
  logic [1:0]       flush_i;
  logic [1:0]       resp_valid_o;
  logic [31:0]      resp_result_o;
  logic [4:0]       resp_waddr_o;
  logic             busy_o;
  logic [31:0]      div_dividend_o;
  logic [31:0]      div_divisor_o;
  logic [2:0]       div_op_o;
  logic [4:0]       div_waddr_o;
  logic             div_start_o;
  logic [31:0]      div_result_i = '0;
  logic             div_ready_i = 1'b0;
  logic             div_busy_i;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_dividend_i(req_dividend_i),
    .req_divisor_i(req_divisor_i), .req_op_i(req_op_i),
    .req_waddr_i(req_waddr_i), .req_ready_o(req_ready_o),
    .flush_i(flush_i), .resp_valid_o(resp_valid_o),
    .resp_result_o(resp_result_o), .resp_waddr_o(resp_waddr_o),
    .busy_o(busy_o), .div_dividend_o(div_dividend_o),
    .div_divisor_o(div_divisor_o), .div_op_o(div_op_o),
    .div_waddr_o(div_waddr_o), .div_start_o(div_start_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_busy_i(div_busy_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_cnt = 0;
  bit st_seen = 0;
  int st_first = -1;
  int st_last = -1;
  int core_cnt = 0;

  typedef struct {
    int          port;
    logic [31:0] res;
    logic [4:0]  wa;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  wa;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] onehot(input int p);
    logic [1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Reference divide semantics of the shared core (truncating, RISC-V style corner cases).
  function automatic logic [31:0] core_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    logic [31:0] r;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Behavioural core: counts start cycles, raises ready for one cycle, aborts when start drops.
  always @(posedge clk) begin
    if (rst || !div_start_o) begin
      core_cnt    <= 0;
      div_ready_i <= 1'b0;
    end else if (!div_ready_i) begin
      if (core_cnt + 1 == ((div_divisor_o == 0) ? 2 : 35)) begin
        div_ready_i  <= 1'b1;
        div_result_i <= core_fn(div_op_o, div_dividend_o, div_divisor_o);
      end else begin
        core_cnt <= core_cnt + 1;
      end
    end
  end
  assign div_busy_i = div_start_o;

  // Output monitor: start-window tracking and scoreboard comparison of responses.
  always @(negedge clk) begin
    exp_t e;
    if (div_start_o) begin
      if (!st_seen) begin
        st_first = cyc;
        st_seen  = 1;
      end
      st_last = cyc;
    end
    if (resp_valid_o != 2'b00) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: valid=%b result=0x%08h (cycle %0d), none expected",
                 resp_valid_o, resp_result_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_port", 32'(resp_valid_o), 32'(onehot(e.port)));
        chk("resp_result", resp_result_o, e.res);
        chk("resp_waddr", 32'(resp_waddr_o), 32'(e.wa));
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        chk("resp_start_gap", 32'(div_start_o), 32'h0);
      end
    end
  end

  task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic [4:0] wa);
    req_valid_i[p]    = 1'b1;
    req_dividend_i[p] = a;
    req_divisor_i[p]  = b;
    req_op_i[p]       = op;
    req_waddr_i[p]    = wa;
  endtask

  task automatic expect_resp(input int p, input logic [31:0] res, input logic [4:0] wa, input int due);
    exp_t e;
    e.port = p;
    e.res  = res;
    e.wa   = wa;
    e.due  = due;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string name, output int g, output logic [1:0] rdy);
    g   = -1;
    rdy = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00) begin
        g   = cyc;
        rdy = req_ready_o;
        break;
      end
    end
    if (g < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no grant within 200 cycles, expected one", name);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses still missing after 300 cycles, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready_o), 32'h0);
    chk({tag, "_resp_valid"}, 32'(resp_valid_o), 32'h0);
    chk({tag, "_resp_result"}, resp_result_o, 32'h0);
    chk({tag, "_resp_waddr"}, 32'(resp_waddr_o), 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_div_start"}, 32'(div_start_o), 32'h0);
    chk({tag, "_div_dividend"}, div_dividend_o, 32'h0);
    chk({tag, "_div_divisor"}, div_divisor_o, 32'h0);
    chk({tag, "_div_op"}, 32'(div_op_o), 32'h0);
    chk({tag, "_div_waddr"}, 32'(div_waddr_o), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 time units");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, g2, rc;
    logic [1:0] rdy;

    vecs[0] = '{0, 32'd100,        32'd7,          OP_DIVU, 5'd5,  32'd14,         37};
    vecs[1] = '{1, 32'hFFFF_FFF9,  32'd2,          OP_REM,  5'd17, 32'hFFFF_FFFF,  37};
    vecs[2] = '{0, 32'd12345,      32'd0,          OP_DIV,  5'd3,  32'hFFFF_FFFF,  4};
    vecs[3] = '{1, 32'd5,          32'd0,          OP_REMU, 5'd30, 32'd5,          4};
    vecs[4] = '{0, 32'hFFFF_FF9C,  32'd7,          OP_DIV,  5'd11, 32'hFFFF_FFF2,  37};
    vecs[5] = '{1, 32'hFFFF_FFFF,  32'd16,         OP_DIVU, 5'd1,  32'h0FFF_FFFF,  37};
    vecs[6] = '{0, 32'h8000_0000,  32'hFFFF_FFFF,  OP_REM,  5'd31, 32'h0,          37};

    rst = 1'b1;
    req_valid_i = '0;
    req_dividend_i = '0;
    req_divisor_i = '0;
    req_op_i = '0;
    req_waddr_i = '0;
    flush_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");
    @(posedge clk);
    #1;

    // Single-port operations from the vector table.
    for (int k = 0; k < 7; k++) begin
      st_seen  = 0;
      st_first = -1;
      st_last  = -1;
      drive_req(vecs[k].port, vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].wa);
      wait_grant($sformatf("vec%0d_grant", k), g, rdy);
      chk($sformatf("vec%0d_ready", k), 32'(rdy), 32'(onehot(vecs[k].port)));
      expect_resp(vecs[k].port, vecs[k].exp_res, vecs[k].wa, g + vecs[k].exp_lat);
      @(posedge clk);
      #1 req_valid_i = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", k), 32'(busy_o), 32'h1);
      drain();
      chk($sformatf("vec%0d_start_first", k), 32'(st_first), 32'(g + 1));
      chk($sformatf("vec%0d_start_last", k), 32'(st_last), 32'(g + vecs[k].exp_lat - 2));
    end

    // Owner flush in cycle 10 hands the core to a waiting port 1.
    drive_req(0, 32'd1000, 32'd10, OP_DIVU, 5'd4);
    wait_grant("flush10_grant", g, rdy);
    chk("flush10_ready", 32'(rdy), 32'h1);
    @(posedge clk);
    #1 req_valid_i = '0;
    drive_req(1, 32'd20, 32'hFFFF_FFFD, OP_DIV, 5'd22);
    repeat (9) @(posedge clk);
    #1 flush_i = 2'b01;
    @(posedge clk);
    #1 flush_i = 2'b00;
    @(negedge clk);
    chk("flush10_regrant_cycle", 32'(cyc), 32'(g + 11));
    chk("flush10_regrant_ready", 32'(req_ready_o), 32'h2);
    chk("flush10_start_low", 32'(div_start_o), 32'h0);
    g2 = cyc;
    expect_resp(1, 32'hFFFF_FFFA, 5'd22, g2 + 37);
    @(posedge clk);
    #1 req_valid_i = '0;
    drain();

    // Owner flush coinciding with core ready suppresses the response.
    drive_req(0, 32'd9, 32'd0, OP_DIVU, 5'd6);
    wait_grant("flushrdy_grant", g, rdy);
    rc = resp_cnt;
    @(posedge clk);
    #1 req_valid_i = '0;
    repeat (2) @(posedge clk);
    #1 flush_i = 2'b01;
    @(posedge clk);
    #1 flush_i = 2'b00;
    @(negedge clk);
    chk("flushrdy_no_resp", 32'(resp_valid_o), 32'h0);
    chk("flushrdy_idle", 32'(busy_o), 32'h0);
    repeat (5) @(negedge clk);
    chk("flushrdy_resp_count", 32'(resp_cnt), 32'(rc));
    @(posedge clk);
    #1;

    // Non-owner flush during BUSY leaves the response intact.
    drive_req(0, 32'd77, 32'd7, OP_DIVU, 5'd8);
    wait_grant("nonowner_grant", g, rdy);
    expect_resp(0, 32'd11, 5'd8, g + 37);
    @(posedge clk);
    #1 req_valid_i = '0;
    @(posedge clk);
    #1 flush_i = 2'b10;
    @(posedge clk);
    #1 flush_i = 2'b00;
    drain();

    // A request flushed in the same IDLE cycle is not granted.
    drive_req(0, 32'd50, 32'd5, OP_DIVU, 5'd2);
    flush_i = 2'b01;
    @(negedge clk);
    chk("idleflush_ready", 32'(req_ready_o), 32'h0);
    @(posedge clk);
    #1 req_valid_i = '0;
    flush_i = 2'b00;
    @(negedge clk);
    chk("idleflush_busy", 32'(busy_o), 32'h0);
    @(posedge clk);
    #1;

    // Reset in cycle 20 of BUSY clears every output next cycle.
    drive_req(0, 32'd1000, 32'd3, OP_DIVU, 5'd7);
    wait_grant("rstmid_grant", g, rdy);
    @(posedge clk);
    #1 req_valid_i = '0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_cycle", 32'(cyc), 32'(g + 21));
    check_zero("rstmid");
    @(posedge clk);
    #1;

    // Both ports keep requesting after reset: strict alternation starting at port 0.
    drive_req(0, 32'd100, 32'd7, OP_DIVU, 5'd5);
    drive_req(1, 32'd5, 32'd0, OP_REMU, 5'd9);
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr%0d_grant", k), g, rdy);
      chk($sformatf("rr%0d_ready", k), 32'(rdy), 32'(onehot(k % 2)));
      if (rdy == 2'b01) expect_resp(0, 32'd14, 5'd5, g + 37);
      else if (rdy == 2'b10) expect_resp(1, 32'd5, 5'd9, g + 4);
    end
    @(posedge clk);
    #1 req_valid_i = '0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
